// File: rtl/i2c_passthru_pkg.sv
// rtl/i2c_passthru_pkg.sv - shared counter indices and read-select type for the passthru stats block
//
// Purpose : counter index map, counter counts, read-select enum and a one-hot
//           decode helper, used by i2c_passthru_evt_stats and its sub-modules.
// Ports   : none (package).
package i2c_passthru_pkg;

   localparam int CNT_IDX_IDLE_TO   = 0;
   localparam int CNT_IDX_BIT_VIOL  = 1;
   localparam int CNT_IDX_CHA_STUCK = 2;
   localparam int CNT_IDX_CHB_STUCK = 3;
   localparam int CNT_IDX_CHA_MST   = 4;
   localparam int CNT_IDX_CHB_MST   = 5;
   localparam int CNT_IDX_BUSY      = 6;

   localparam int NUM_CNT     = 7;
   localparam int ERR_CNT_NUM = 4;

   typedef enum logic [2:0] {
      SEL_IDLE_TO   = 3'd0,
      SEL_BIT_VIOL  = 3'd1,
      SEL_CHA_STUCK = 3'd2,
      SEL_CHB_STUCK = 3'd3,
      SEL_CHA_MST   = 3'd4,
      SEL_CHB_MST   = 3'd5,
      SEL_BUSY      = 3'd6,
      SEL_RSVD      = 3'd7
   } rd_sel_t;

   // One-hot over the implemented counters; the reserved index maps to no counter.
   function automatic logic [NUM_CNT-1:0] rd_sel_onehot(input rd_sel_t sel);
      logic [NUM_CNT-1:0] oh;
      oh = '0;
      for (int k = 0; k < NUM_CNT; k++) begin
         oh[k] = (sel == rd_sel_t'(k[2:0]));
      end
      return oh;
   endfunction

endpackage

// File: rtl/i2c_passthru_sat_cnt.sv
// rtl/i2c_passthru_sat_cnt.sv - saturating event counter with sticky saturation flag
//
// Purpose : WIDTH-bit up counter that holds at all-ones. o_sat sets when the
//           counter reaches all-ones and clears only when the counter is cleared.
//           Clear and increment together leave the counter at 1 so a same-cycle
//           event is not lost across a clear.
// Ports   : i_clk, i_rst (sync, active-high), i_inc (count enable),
//           i_clr (clear), o_cnt (count), o_sat (sticky saturation flag).
module i2c_passthru_sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_sat
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = i_inc ? ONE : '0;
      end else if (i_inc && (cnt_q != ALL_ONES)) begin
         cnt_d = cnt_q + ONE;
      end
      sat_d = (cnt_d == ALL_ONES) | (sat_q & ~i_clr);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   assign o_cnt = cnt_q;
   assign o_sat = sat_q;

endmodule

// File: rtl/i2c_passthru_evt_stats.sv
// rtl/i2c_passthru_evt_stats.sv - per-event saturating statistics with registered read port and error irq
//
// Purpose : counts passthru status events (idle timeout, bit violation, per-channel
//           stuck, per-channel master starts, optional busy time), serves counters on
//           a registered read port with optional clear-on-read, raises a maskable
//           error interrupt.
// Config  : `define I2C_PASSTHRU_STATS_BUSY_TIME_EN builds the busy-time counter (index 6);
//           otherwise index 6 reads 0, o_sat[6] is 0 and i_f_ref_slow is unused.
// Ports   : i_clk, i_rst (sync, active-high), i_f_ref_slow (slow tick),
//           i_cha_ismst / i_chb_ismst (levels), i_idle_timeout, i_bit_violation,
//           i_cha_stuck, i_chb_stuck (pulses), i_rd_en, i_rd_sel, i_clr_all,
//           o_rd_data, o_rd_valid, o_sat[6:0], o_err_irq.
module i2c_passthru_evt_stats
   import i2c_passthru_pkg::*;
#(
   parameter int         CNT_WIDTH = 16,
   parameter bit         CLR_ON_RD = 1'b1,
   parameter logic [3:0] IRQ_MASK  = 4'b1111
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_f_ref_slow,
   input  logic                 i_cha_ismst,
   input  logic                 i_chb_ismst,
   input  logic                 i_idle_timeout,
   input  logic                 i_bit_violation,
   input  logic                 i_cha_stuck,
   input  logic                 i_chb_stuck,
   input  logic                 i_rd_en,
   input  logic [2:0]           i_rd_sel,
   input  logic                 i_clr_all,
   output logic [CNT_WIDTH-1:0] o_rd_data,
   output logic                 o_rd_valid,
   output logic [6:0]           o_sat,
   output logic                 o_err_irq
);

   logic                   cha_mst_q, cha_mst_d;
   logic                   chb_mst_q, chb_mst_d;
   logic [CNT_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   err_irq_q, err_irq_d;

   logic [NUM_CNT-1:0]     evt, inc, clr, rd_hit, sat;
   logic [CNT_WIDTH-1:0]   cnt [NUM_CNT];
   logic [ERR_CNT_NUM-1:0] err_nz_next;
   rd_sel_t                rd_sel;

   assign rd_sel = rd_sel_t'(i_rd_sel);
   assign rd_hit = i_rd_en ? rd_sel_onehot(rd_sel) : '0;

   always_comb begin
      evt                    = '0;
      evt[CNT_IDX_IDLE_TO]   = i_idle_timeout;
      evt[CNT_IDX_BIT_VIOL]  = i_bit_violation;
      evt[CNT_IDX_CHA_STUCK] = i_cha_stuck;
      evt[CNT_IDX_CHB_STUCK] = i_chb_stuck;
      // Master starts are rising edges against the registered level; the edge
      // register resets to 0 so a level already high out of reset counts once.
      evt[CNT_IDX_CHA_MST]   = i_cha_ismst & ~cha_mst_q;
      evt[CNT_IDX_CHB_MST]   = i_chb_ismst & ~chb_mst_q;
`ifdef I2C_PASSTHRU_STATS_BUSY_TIME_EN
      evt[CNT_IDX_BUSY]      = i_f_ref_slow & (i_cha_ismst | i_chb_ismst);
`endif
      // Clear-all drops same-cycle events; clear-on-read keeps them (counter -> 1).
      inc = evt & ~{NUM_CNT{i_clr_all}};
      clr = {NUM_CNT{i_clr_all}} | (CLR_ON_RD ? rd_hit : '0);
   end

   for (genvar k = 0; k < CNT_IDX_BUSY; k++) begin : g_cnt
      i2c_passthru_sat_cnt #(.WIDTH(CNT_WIDTH)) u_cnt (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .i_inc (inc[k]),
         .i_clr (clr[k]),
         .o_cnt (cnt[k]),
         .o_sat (sat[k])
      );
   end

`ifdef I2C_PASSTHRU_STATS_BUSY_TIME_EN
   i2c_passthru_sat_cnt #(.WIDTH(CNT_WIDTH)) u_busy_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (inc[CNT_IDX_BUSY]),
      .i_clr (clr[CNT_IDX_BUSY]),
      .o_cnt (cnt[CNT_IDX_BUSY]),
      .o_sat (sat[CNT_IDX_BUSY])
   );
`else
   logic unused_busy;
   assign cnt[CNT_IDX_BUSY] = '0;
   assign sat[CNT_IDX_BUSY] = 1'b0;
   assign unused_busy       = ^{i_f_ref_slow, inc[CNT_IDX_BUSY], clr[CNT_IDX_BUSY]};
`endif

   always_comb begin
      cha_mst_d  = i_cha_ismst;
      chb_mst_d  = i_chb_ismst;
      rd_valid_d = i_rd_en;
      rd_data_d  = rd_data_q;
      // Read returns the pre-update value; the reserved index has no hit and reads 0.
      if (i_rd_en) begin
         rd_data_d = '0;
         for (int k = 0; k < NUM_CNT; k++) begin
            if (rd_hit[k]) begin
               rd_data_d = cnt[k];
            end
         end
      end
      // Non-zero state of each error counter after this cycle's update, so the
      // registered irq tracks the counters with no extra cycle of lag.
      for (int k = 0; k < ERR_CNT_NUM; k++) begin
         err_nz_next[k] = clr[k] ? inc[k] : ((cnt[k] != '0) || inc[k]);
      end
      err_irq_d = |(IRQ_MASK & err_nz_next);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cha_mst_q  <= 1'b0;
         chb_mst_q  <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         err_irq_q  <= 1'b0;
      end else begin
         cha_mst_q  <= cha_mst_d;
         chb_mst_q  <= chb_mst_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         err_irq_q  <= err_irq_d;
      end
   end

   assign o_rd_data  = rd_data_q;
   assign o_rd_valid = rd_valid_q;
   assign o_sat      = sat;
   assign o_err_irq  = err_irq_q;

endmodule

// File: tb/tb_i2c_passthru_evt_stats.sv
// tb/tb_i2c_passthru_evt_stats.sv - self-checking bench for i2c_passthru_evt_stats
//
// Purpose : two instances (16-bit full mask, 2-bit with cha_stuck masked) share
//           stimulus; directed scenarios plus a randomized run against a
//           behavioural event/counter model.
// Ports   : none (top-level bench).
module tb_i2c_passthru_evt_stats;

   logic       clk;
   logic       rst;
   logic       ref_slow, cha, chb, idle, bv, cas, cbs, rd_en, clr_all;
   logic [2:0] sel;

   logic [15:0] rd_data0;
   logic [1:0]  rd_data1;
   logic        rd_valid0, rd_valid1, irq0, irq1;
   logic [6:0]  sat0, sat1;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state, index 0 = dut0, 1 = dut1.
   int       m_cnt [2][8];
   bit       m_sat [2][8];
   int       m_rdata [2];
   bit       m_rvalid [2];
   bit       m_irq [2];
   bit       m_cha_prev, m_chb_prev;
   int       m_max [2]  = '{65535, 3};
   bit [3:0] m_mask [2] = '{4'b1111, 4'b1011};

`ifdef I2C_PASSTHRU_STATS_BUSY_TIME_EN
   localparam bit BUSY_EN = 1'b1;
`else
   localparam bit BUSY_EN = 1'b0;
`endif

   i2c_passthru_evt_stats dut0 (
      .i_clk(clk), .i_rst(rst), .i_f_ref_slow(ref_slow),
      .i_cha_ismst(cha), .i_chb_ismst(chb),
      .i_idle_timeout(idle), .i_bit_violation(bv),
      .i_cha_stuck(cas), .i_chb_stuck(cbs),
      .i_rd_en(rd_en), .i_rd_sel(sel), .i_clr_all(clr_all),
      .o_rd_data(rd_data0), .o_rd_valid(rd_valid0), .o_sat(sat0), .o_err_irq(irq0)
   );

   i2c_passthru_evt_stats #(.CNT_WIDTH(2), .CLR_ON_RD(1'b1), .IRQ_MASK(4'b1011)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_f_ref_slow(ref_slow),
      .i_cha_ismst(cha), .i_chb_ismst(chb),
      .i_idle_timeout(idle), .i_bit_violation(bv),
      .i_cha_stuck(cas), .i_chb_stuck(cbs),
      .i_rd_en(rd_en), .i_rd_sel(sel), .i_clr_all(clr_all),
      .o_rd_data(rd_data1), .o_rd_valid(rd_valid1), .o_sat(sat1), .o_err_irq(irq1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle of the reference: events this cycle, then what each counter holds after it.
   task automatic model_step();
      bit [6:0] ev;
      ev[0] = idle;
      ev[1] = bv;
      ev[2] = cas;
      ev[3] = cbs;
      ev[4] = cha && !m_cha_prev;
      ev[5] = chb && !m_chb_prev;
      ev[6] = BUSY_EN && ref_slow && (cha || chb);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            for (int k = 0; k < 8; k++) begin
               m_cnt[i][k] = 0;
               m_sat[i][k] = 0;
            end
            m_rdata[i]  = 0;
            m_rvalid[i] = 0;
            m_irq[i]    = 0;
         end else begin
            m_rvalid[i] = rd_en;
            if (rd_en) m_rdata[i] = (sel == 3'd7) ? 0 : m_cnt[i][sel];
            for (int k = 0; k < 7; k++) begin
               if (clr_all) begin
                  m_cnt[i][k] = 0;
                  m_sat[i][k] = 0;
               end else if (rd_en && (int'(sel) == k)) begin
                  m_cnt[i][k] = ev[k] ? 1 : 0;
                  m_sat[i][k] = 0;
               end else if (ev[k] && (m_cnt[i][k] < m_max[i])) begin
                  m_cnt[i][k] = m_cnt[i][k] + 1;
                  if (m_cnt[i][k] == m_max[i]) m_sat[i][k] = 1;
               end
            end
            m_irq[i] = 0;
            for (int k = 0; k < 4; k++) begin
               if (m_mask[i][k] && (m_cnt[i][k] != 0)) m_irq[i] = 1;
            end
         end
      end
      m_cha_prev = rst ? 1'b0 : cha;
      m_chb_prev = rst ? 1'b0 : chb;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (rd_valid0 !== 1'b0 || rd_data0 !== 16'd0 || sat0 !== 7'd0 || irq0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_dut0 valid=%0b data=%0d sat=%b irq=%0b expected all 0", rd_valid0, rd_data0, sat0, irq0);
      end
      checks++;
      if (rd_valid1 !== 1'b0 || rd_data1 !== 2'd0 || sat1 !== 7'd0 || irq1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_dut1 valid=%0b data=%0d sat=%b irq=%0b expected all 0", rd_valid1, rd_data1, sat1, irq1);
      end
      for (int s = 0; s < 8; s++) begin
         rd_en = 1'b1;
         sel   = 3'(s);
         tick();
         rd_en = 1'b0;
         checks++;
         if (rd_valid0 !== 1'b1 || rd_data0 !== 16'd0 || irq0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_read sel=%0d valid=%0b data=%0d irq=%0b expected valid=1 data=0 irq=0", s, rd_valid0, rd_data0, irq0);
         end
         tick();
         checks++;
         if (rd_valid0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_read_pulse sel=%0d valid=%0b expected 0", s, rd_valid0);
         end
      end
   endtask

   task automatic test_clear_on_read();
      for (int p = 0; p < 5; p++) begin
         bv = 1'b1;
         tick();
         bv = 1'b0;
         if (p == 0) begin
            checks++;
            if (irq0 !== 1'b1) begin
               failures++;
               $display("FAIL irq_rise irq=%0b expected 1", irq0);
            end
         end
         tick();
      end
      rd_en = 1'b1;
      sel   = 3'd1;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_data0 !== 16'd5 || rd_data1 !== 2'd3) begin
         failures++;
         $display("FAIL bitviol_read data0=%0d data1=%0d expected 5 and 3", rd_data0, rd_data1);
      end
      checks++;
      if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
         failures++;
         $display("FAIL irq_fall irq0=%0b irq1=%0b expected 0", irq0, irq1);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_data0 !== 16'd0) begin
         failures++;
         $display("FAIL bitviol_reread data=%0d expected 0", rd_data0);
      end
   endtask

   task automatic test_saturation();
      for (int p = 0; p < 4; p++) begin
         cas = 1'b1;
         tick();
         cas = 1'b0;
         tick();
      end
      checks++;
      if (sat1[2] !== 1'b1 || sat0[2] !== 1'b0) begin
         failures++;
         $display("FAIL sat_flag sat1=%b sat0=%b expected sat1[2]=1 sat0[2]=0", sat1, sat0);
      end
      checks++;
      if (irq1 !== 1'b0 || irq0 !== 1'b1) begin
         failures++;
         $display("FAIL irq_mask irq1=%0b irq0=%0b expected 0 and 1", irq1, irq0);
      end
      rd_en = 1'b1;
      sel   = 3'd2;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_data1 !== 2'd3 || rd_data0 !== 16'd4 || sat1[2] !== 1'b0) begin
         failures++;
         $display("FAIL sat_read data1=%0d data0=%0d sat1=%b expected 3 4 sat1[2]=0", rd_data1, rd_data0, sat1);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_data1 !== 2'd0) begin
         failures++;
         $display("FAIL sat_reread data1=%0d expected 0", rd_data1);
      end
   endtask

   task automatic test_mst_starts();
      cha = 1'b1;
      repeat (10) tick();
      cha = 1'b0;
      tick();
      cha = 1'b1;
      repeat (2) tick();
      cha = 1'b0;
      rd_en = 1'b1;
      sel   = 3'd4;
      tick();
      sel = 3'd5;
      checks++;
      if (rd_data0 !== 16'd2 || rd_data1 !== 2'd2) begin
         failures++;
         $display("FAIL cha_starts data0=%0d data1=%0d expected 2", rd_data0, rd_data1);
      end
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_data0 !== 16'd0) begin
         failures++;
         $display("FAIL chb_starts data=%0d expected 0", rd_data0);
      end
   endtask

   task automatic test_read_with_event();
      repeat (3) begin
         idle = 1'b1;
         tick();
         idle = 1'b0;
         tick();
      end
      idle  = 1'b1;
      rd_en = 1'b1;
      sel   = 3'd0;
      tick();
      idle = 1'b0;
      checks++;
      if (rd_data0 !== 16'd3 || rd_data1 !== 2'd3) begin
         failures++;
         $display("FAIL read_evt data0=%0d data1=%0d expected 3", rd_data0, rd_data1);
      end
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_data0 !== 16'd1) begin
         failures++;
         $display("FAIL read_evt_kept data=%0d expected 1", rd_data0);
      end
      repeat (2) begin
         idle = 1'b1;
         tick();
         idle = 1'b0;
      end
      idle    = 1'b1;
      clr_all = 1'b1;
      rd_en   = 1'b1;
      tick();
      idle    = 1'b0;
      clr_all = 1'b0;
      checks++;
      if (rd_data0 !== 16'd2) begin
         failures++;
         $display("FAIL clr_all_read data=%0d expected 2", rd_data0);
      end
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_data0 !== 16'd0 || sat0 !== 7'd0 || irq0 !== 1'b0) begin
         failures++;
         $display("FAIL clr_all_drop data=%0d sat=%b irq=%0b expected 0", rd_data0, sat0, irq0);
      end
   endtask

   task automatic test_busy_time();
      cha = 1'b1;
      for (int t = 0; t < 4; t++) begin
         ref_slow = 1'b1;
         tick();
         ref_slow = 1'b0;
         repeat (2) tick();
      end
      cha      = 1'b0;
      ref_slow = 1'b1;
      tick();
      ref_slow = 1'b0;
      rd_en = 1'b1;
      sel   = 3'd6;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_data0 !== (BUSY_EN ? 16'd4 : 16'd0) || rd_data1 !== (BUSY_EN ? 2'd3 : 2'd0)) begin
         failures++;
         $display("FAIL busy_time data0=%0d data1=%0d busy_en=%0b", rd_data0, rd_data1, BUSY_EN);
      end
   endtask

   task automatic test_reset_mid_read();
      rd_en = 1'b1;
      sel   = 3'd1;
      rst   = 1'b1;
      tick();
      rst   = 1'b0;
      rd_en = 1'b0;
      checks++;
      if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_read valid0=%0b valid1=%0b expected 0", rd_valid0, rd_valid1);
      end
      tick();
   endtask

   task automatic test_random();
      logic [15:0] a_data [2];
      logic        a_valid [2];
      logic        a_irq [2];
      logic [6:0]  a_sat [2];
      logic [6:0]  e_sat;
      for (int c = 0; c < 600; c++) begin
         idle     = ($urandom_range(0, 3) == 0);
         bv       = ($urandom_range(0, 3) == 0);
         cas      = ($urandom_range(0, 3) == 0);
         cbs      = ($urandom_range(0, 5) == 0);
         ref_slow = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) cha = ~cha;
         if ($urandom_range(0, 7) == 0) chb = ~chb;
         rd_en    = ($urandom_range(0, 1) == 0);
         sel      = 3'($urandom_range(0, 7));
         clr_all  = ($urandom_range(0, 49) == 0);
         rst      = ($urandom_range(0, 149) == 0);
         tick();
         a_data[0] = rd_data0;           a_data[1] = {14'd0, rd_data1};
         a_valid[0] = rd_valid0;         a_valid[1] = rd_valid1;
         a_irq[0] = irq0;                a_irq[1] = irq1;
         a_sat[0] = sat0;                a_sat[1] = sat1;
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 7; k++) e_sat[k] = m_sat[i][k];
            checks++;
            if (a_valid[i] !== m_rvalid[i] || (m_rvalid[i] && a_data[i] !== 16'(m_rdata[i]))) begin
               failures++;
               $display("FAIL rand_read dut%0d cyc=%0d valid=%0b data=%0d expected valid=%0b data=%0d",
                        i, c, a_valid[i], a_data[i], m_rvalid[i], m_rdata[i]);
            end
            checks++;
            if (a_sat[i] !== e_sat || a_irq[i] !== m_irq[i]) begin
               failures++;
               $display("FAIL rand_status dut%0d cyc=%0d sat=%b irq=%0b expected sat=%b irq=%0b",
                        i, c, a_sat[i], a_irq[i], e_sat, m_irq[i]);
            end
         end
      end
      {idle, bv, cas, cbs, ref_slow, rd_en, clr_all, rst} = '0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      {ref_slow, cha, chb, idle, bv, cas, cbs, rd_en, clr_all} = '0;
      sel = 3'd0;
      m_cha_prev = 1'b0;
      m_chb_prev = 1'b0;
      test_reset();
      test_clear_on_read();
      test_saturation();
      test_mst_starts();
      test_read_with_event();
      test_busy_time();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
